// File: rtl/histogram_engine_if.sv
// Sample-in and readout-out streams of histogram_engine.
// slave: the engine side; master: the source/sink side.
interface histogram_engine_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_bin;
    logic [CNT_W-1:0]  m_count;
    logic              m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_bin, m_count, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_bin, m_count, m_last
    );
endinterface

// File: rtl/histogram_engine.sv
// histogram_engine: counts occurrences of each DATA_W-bit sample in a bin RAM.
// CLEAR sweeps the RAM to zero, ACCUM runs a two-stage read/increment/write
// pipeline with same-bin forwarding, DRAIN empties that pipeline, and DUMP
// streams every bin out under backpressure.
// Build option HIST_SATURATE_EN: bins stick at their maximum instead of
// wrapping to zero. In both builds, ovf is set by the first increment that
// finds a bin already at its maximum.
module histogram_engine #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr_req,
    input  logic                    rd_req,
    histogram_engine_if.slave       bus,
    output logic [CNT_W+DATA_W-1:0] total,
    output logic                    ovf,
    output logic                    busy
);
    localparam int                NBINS    = 2**DATA_W;
    localparam logic [DATA_W-1:0] LAST_BIN = DATA_W'(NBINS - 1);

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;

    state_t            state, state_nxt;
    state_t            tgt, tgt_nxt;

    logic [CNT_W-1:0]  ram [NBINS];
    logic [CNT_W-1:0]  ram_q;
    logic [DATA_W-1:0] rd_addr;
    logic [DATA_W-1:0] addr, addr_nxt;

    logic              s0_valid;
    logic [DATA_W-1:0] s0_bin;
    logic              s0_hit;
    logic [CNT_W-1:0]  s0_fwd;
    logic [CNT_W-1:0]  cur_cnt, wr_val;
    logic              at_max;

    logic              accept, beat_done, stats_clr, dump_rd;
    logic              m_valid_r, m_last_r;
    logic [DATA_W-1:0] m_bin_r;
    logic [CNT_W-1:0]  m_count_r;

    assign accept    = bus.s_valid && (state == ACCUM);
    assign beat_done = m_valid_r && bus.m_ready;
    assign stats_clr = (state == DRAIN) && !s0_valid && (tgt == CLEAR);

    // A back-to-back sample to the same bin must see the value about to be
    // written, not the stale RAM word read in the same cycle.
    assign cur_cnt = s0_hit ? s0_fwd : ram_q;
    assign at_max  = &cur_cnt;
`ifdef HIST_SATURATE_EN
    assign wr_val  = at_max ? cur_cnt : cur_cnt + CNT_W'(1);
`else
    assign wr_val  = cur_cnt + CNT_W'(1);
`endif

    // State register: the FSM state and the state to enter once DRAIN is done.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            tgt   <= CLEAR;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
        end
    end

    // Next-state logic; in ACCUM, a clear request beats a simultaneous readout.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        case (state)
            CLEAR: if (addr == LAST_BIN) state_nxt = ACCUM;
            ACCUM: begin
                if (clr_req) begin
                    state_nxt = DRAIN;
                    tgt_nxt   = CLEAR;
                end else if (rd_req) begin
                    state_nxt = DRAIN;
                    tgt_nxt   = DUMP;
                end
            end
            DRAIN: if (!s0_valid) state_nxt = tgt;
            DUMP:  if (beat_done && m_last_r) state_nxt = ACCUM;
            default: state_nxt = CLEAR;
        endcase
    end

    // Sweep/dump address: steps through CLEAR, advances per accepted beat in DUMP.
    always_comb begin
        addr_nxt = '0;
        case (state)
            CLEAR:   addr_nxt = addr + DATA_W'(1);
            DUMP:    addr_nxt = (beat_done && !m_last_r) ? addr + DATA_W'(1) : addr;
            default: addr_nxt = '0;
        endcase
        rd_addr = (state == DUMP) ? addr_nxt : bus.s_data;
    end

    // Address register, parked at zero so CLEAR and DUMP both start at bin 0.
    always_ff @(posedge CLK) begin
        if (RST) addr <= '0;
        else     addr <= addr_nxt;
    end

    // Bin RAM: one write port (clear sweep or increment) and one synchronous read.
    // NOTE: bin storage has no reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge CLK) begin
        if (state == CLEAR)  ram[addr]   <= '0;
        else if (s0_valid)   ram[s0_bin] <= wr_val;
        ram_q <= ram[rd_addr];
    end

    // Update pipeline: capture the accepted bin and note a same-bin follow-on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s0_valid <= 1'b0;
            s0_bin   <= '0;
            s0_hit   <= 1'b0;
            s0_fwd   <= '0;
        end else begin
            s0_valid <= accept;
            s0_bin   <= bus.s_data;
            s0_hit   <= s0_valid && (s0_bin == bus.s_data);
            s0_fwd   <= wr_val;
        end
    end

    // Running total and sticky overflow; a clear request zeroes both.
    always_ff @(posedge CLK) begin
        if (RST) begin
            total <= '0;
            ovf   <= 1'b0;
        end else if (stats_clr) begin
            total <= '0;
            ovf   <= 1'b0;
        end else begin
            if (accept)             total <= total + (CNT_W+DATA_W)'(1);
            if (s0_valid && at_max) ovf   <= 1'b1;
        end
    end

    // Readout register: loads a beat once the RAM word for addr has arrived,
    // then holds it until the sink takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dump_rd   <= 1'b0;
            m_valid_r <= 1'b0;
            m_bin_r   <= '0;
            m_count_r <= '0;
            m_last_r  <= 1'b0;
        end else begin
            dump_rd <= (state == DUMP);
            if (beat_done) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end else if ((state == DUMP) && dump_rd && !m_valid_r) begin
                m_valid_r <= 1'b1;
                m_bin_r   <= addr;
                m_count_r <= ram_q;
                m_last_r  <= (addr == LAST_BIN);
            end
        end
    end

    assign bus.s_ready = (state == ACCUM);
    assign bus.m_valid = m_valid_r;
    assign bus.m_bin   = m_bin_r;
    assign bus.m_count = m_count_r;
    assign bus.m_last  = m_last_r;
    assign busy        = (state != ACCUM) || s0_valid;
endmodule
